ret_stack: RTL

//  Hardware return-address stack (istack) for subroutine calls. Consumes the control unit's we_istack/s_jret

---
 rtl/ret_stack_if.sv | 28 ++
 rtl/ret_stack.sv | 68 ++++++
 2 files changed

// File: rtl/ret_stack_if.sv
// Control-unit to return-address-stack bus.
// Master drives push/pop strobes; slave returns top-of-stack and status.
interface ret_stack_if #(
   parameter int PC_W  = 10,
   parameter int DEPTH = 16
);
   localparam int PTR_W = $clog2(DEPTH);

   logic            we_istack;
   logic            s_jret;
   logic [PC_W-1:0] pc_link;
   logic [PC_W-1:0] ret_addr;
   logic [PTR_W:0]  sp;
   logic            empty;
   logic            full;
   logic            ovf;
   logic            unf;

   modport master (
      output we_istack, s_jret, pc_link,
      input  ret_addr, sp, empty, full, ovf, unf
   );

   modport slave (
      input  we_istack, s_jret, pc_link,
      output ret_addr, sp, empty, full, ovf, unf
   );
endinterface

// File: rtl/ret_stack.sv
// Hardware return-address stack: JAL pushes PC+1, RET pops.
// Top-of-stack is combinational so RET resolves in the same cycle.
module ret_stack #(
   parameter int PC_W  = 10,
   parameter int DEPTH = 16
) (
   input  logic         clk,
   input  logic         reset,
   ret_stack_if.slave   bus
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0]   SP_ONE  = 1;
   localparam logic [PTR_W:0]   SP_FULL = DEPTH[PTR_W:0];
   localparam logic [PTR_W-1:0] IX_ONE  = 1;

   logic [PC_W-1:0]  r_mem [DEPTH];
   logic [PTR_W:0]   r_sp;
   logic             r_ovf;
   logic             r_unf;

   logic             w_push;
   logic             w_pop;
   logic             w_empty;
   logic             w_full;
   logic [PTR_W-1:0] w_wr_ix;
   logic [PTR_W-1:0] w_top_ix;

   assign w_push   = bus.we_istack & ~bus.s_jret;
   assign w_pop    = bus.we_istack &  bus.s_jret;
   assign w_empty  = (r_sp == '0);
   assign w_full   = (r_sp == SP_FULL);
   assign w_wr_ix  = r_sp[PTR_W-1:0];
   // At full, the low bits wrap to 0 so minus one still lands on DEPTH-1.
   assign w_top_ix = r_sp[PTR_W-1:0] - IX_ONE;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_sp  <= '0;
         r_ovf <= 1'b0;
         r_unf <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else begin
         if (w_push) begin
            if (w_full) begin
               r_ovf <= 1'b1;
            end else begin
               r_mem[w_wr_ix] <= bus.pc_link;
               r_sp           <= r_sp + SP_ONE;
            end
         end else if (w_pop) begin
            if (w_empty) begin
               r_unf <= 1'b1;
            end else begin
               r_sp <= r_sp - SP_ONE;
            end
         end
      end
   end

   assign bus.ret_addr = w_empty ? '0 : r_mem[w_top_ix];
   assign bus.sp       = r_sp;
   assign bus.empty    = w_empty;
   assign bus.full     = w_full;
   assign bus.ovf      = r_ovf;
   assign bus.unf      = r_unf;
endmodule
